abc_scaled_hs: RTL and testbench
================================

# abc_scaled_hs

Parametrised successor of the two-operand add-and-double unit. It captures `a`, `b`, a runtime multiplier `m` and a `mode` bit over the input `_dav`/`rfd` handshake. It then computes `p = m*(a+b)` or `p = m*|a-b|` with a multi-cycle shift-add multiplier, and delivers `p` over a second `_dav_out`/`rfd_out` handshake to a downstream consumer. It sits between an operand producer and a result consumer.

## Interface
- `W`, 4: width of operands `a`, `b`.
- `MW`, 3: width of multiplier `m`; also the fixed number of multiply cycles.
- `PW`, `W+1+MW`: result width (derived, not overridable).
- `clock`  in  1  system clock; all state changes on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `a`  in  W  operand A, unsigned; valid while `_dav`=0.
- `b`  in  W  operand B, unsigned; valid while `_dav`=0.
- `m`  in  MW  multiplier, unsigned; valid while `_dav`=0.
- `mode`  in  1  0: sum; 1: absolute difference.
- `_dav`  in  1  active-low data-available from the producer.
- `rfd`  out  1  ready-for-data to the producer; registered.
- `p`  out  PW  result; registered, held between deliveries.
- `_dav_out`  out  1  active-low result-available to the consumer; registered.
- `rfd_out`  in  1  consumer ready; goes 0 to acknowledge `p`.

## Operation
- Reset values:
  - `rfd`=1, `_dav_out`=1, `p`=0.
  - state IDLE, internal accumulator and counter 0.
- FSM states and transitions:
  - **IDLE** (`rfd`=1): on a posedge sampling `_dav`=0:
    - latch `a`, `b`, `m`, `mode`;
    - compute `s = mode ? |a-b| : a+b` (W+1 bits, unsigned);
    - set `rfd`<=0, go WAIT.
  - **WAIT** (`rfd`=0): on `_dav`=1, load `acc`=0, `mcand`=`s` zero-extended to PW, `mplier`=`m`, `cnt`=MW, go MUL.
  - **MUL**: each cycle:
    - if `mplier[0]`, `acc += mcand`;
    - `mcand <<= 1`, `mplier >>= 1`, `cnt--`.
    - When `cnt` reaches 0, set `p`<=final `acc`, `_dav_out`<=0, go OUT. This is exactly MW cycles, independent of the value of `m`.
  - **OUT** (`_dav_out`=0): on `rfd_out`=0, set `_dav_out`<=1, go ACK.
  - **ACK**: on `rfd_out`=1, set `rfd`<=1, go IDLE.
- Arithmetic rules:
  - no overflow is possible: max `p` = (2^(W+1)-2)*(2^MW-1) < 2^PW;
  - `|a-b|` is computed with `a`≥`b` compared first, never as a wrapped subtraction.
- Boundary conditions:
  - `m`=0: `p`=0, full handshake still performed.
  - `a`=`b` with `mode`=1: `p`=0.
  - `_dav` still 0 on WAIT entry: stay in WAIT. No second capture until IDLE is re-entered.
  - `rfd_out` already 0 on OUT entry: acknowledge on the first OUT cycle; `_dav_out` is low for exactly one cycle.
  - `_dav` low during OUT/ACK: ignored; captured after return to IDLE.
  - `reset` in any state: all outputs and state return to reset values on that edge. The pending result is discarded and never presented.
- `p` changes only on MUL→OUT, and only while `_dav_out` is 1 → 0.

## Timing
- Edge 0: capture in IDLE; `rfd` falls after that edge.
- WAIT lasts ≥1 cycle, until the producer raises `_dav`.
- MUL: MW cycles. `p` and `_dav_out`=0 become valid MW edges after the WAIT→MUL edge.
- Minimum capture-to-`_dav_out` latency: MW+2 clocks.
- Minimum total turnaround, capture to `rfd`=1: MW+4 clocks.
- Outputs are purely registered; there is no combinational path from any input to `rfd`, `p` or `_dav_out`.

## Structure
- Package `abc_pkg`:
  - state enum IDLE/WAIT/MUL/OUT/ACK (3-bit encoding);
  - function `pw(W,MW)` returning result width.
- Sub-module `shift_add_mul`, parametrised (W+1, MW):
  - ports: `clock`, `reset`, `start`, `s`, `m`;
  - outputs: `done` (1-cycle pulse), `prod`.
- The top-level FSM owns both handshakes and the `p` register.

## Test plan
- **Backward compatibility:** W=4, MW=3, `mode`=0, `m`=2, 32 pairs with `a`=i[4:1]+3, `b`=i[3:0]+1 → `p`=2*(`a`+`b`) each, in order, every handshake completed.
- **Difference mode:** `a`=3, `b`=12, `mode`=1, `m`=5 → `p`=45. Then `a`=`b`=9 → `p`=0.
- **Extremes:** `a`=`b`=15, `m`=7, `mode`=0 → `p`=210. Then `m`=0 → `p`=0, `_dav_out` still pulses low.
- **Slow consumer / fast consumer:**
  - `rfd_out` held 1 for 20 cycles after `_dav_out` falls → `p` stable, `rfd` stays 0 throughout;
  - `rfd_out` tied 0 → `_dav_out` low exactly 1 cycle.
- **Reset mid-operation:** assert `reset` for 1 cycle during MUL → `rfd`=1, `_dav_out`=1, `p`=0 next edge; no stale result appears. The next transaction returns the correct value.
- **Latency check:** producer raises `_dav` immediately; consumer acks immediately → capture-to-`_dav_out` = MW+2 clocks, turnaround = MW+4 clocks. Repeat at W=8, MW=5.

Source files
------------

// File: rtl/abc_pkg.sv
// Shared types and helpers for the scaled add/difference unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding and the derived result-width helper.
package abc_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_MUL  = 3'd2,
        S_OUT  = 3'd3,
        S_ACK  = 3'd4
    } state_t;

    // Result width: one carry bit on the W-bit sum/difference plus the
    // multiplier width, which is enough for the largest possible product.
    function automatic int pw(input int w, input int mw);
        return w + 1 + mw;
    endfunction

endpackage

// File: rtl/shift_add_mul.sv
// Fixed-length shift-add multiplier: prod = s * m.
// Latency: exactly MW cycles after start, regardless of the value of m.
// Backpressure: none; start is only issued while idle, done/prod are a 1-cycle strobe.
//
// Ports: clock, reset (sync, active-high); start loads s/m; done pulses high
// during the final step and prod carries the completed product in that cycle.
module shift_add_mul
    import abc_pkg::*;
#(
    parameter int  SW = 5,
    parameter int  MW = 3,
    localparam int PW = pw(SW - 1, MW)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [SW-1:0] s,
    input  logic [MW-1:0] m,
    output logic          done,
    output logic [PW-1:0] prod
);

    localparam int CW = $clog2(MW + 1);

    logic [PW-1:0] acc;
    logic [PW-1:0] mcand;
    logic [MW-1:0] mplier;
    logic [CW-1:0] cnt;
    logic          busy;
    logic [PW-1:0] acc_nxt;

    always_comb begin
        acc_nxt = acc;
        if (mplier[0]) begin
            acc_nxt = acc + mcand;
        end
    end

    // The last step's sum is handed out combinationally so the caller can
    // register it on the same edge the counter expires.
    assign done = busy && (cnt == CW'(1));
    assign prod = acc_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= PW'(s);
            mplier <= m;
            cnt    <= CW'(MW);
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/abc_scaled_hs.sv
// Captures a, b, m, mode and returns p = m*(a+b) or m*|a-b| over a second handshake.
// Latency: MW+2 clocks capture-to-result minimum, MW+4 clocks to ready again.
// Backpressure: rfd held low until the consumer has taken p; p held until acknowledged.
//
// Ports: clock, reset (sync, active-high); producer side a, b, m, mode, _dav (low =
// data available), rfd (ready); consumer side p, _dav_out (low = result available),
// rfd_out (consumer drops it to acknowledge). All outputs are registered.
module abc_scaled_hs
    import abc_pkg::*;
#(
    parameter int  W  = 4,
    parameter int  MW = 3,
    localparam int PW = pw(W, MW)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [MW-1:0] m,
    input  logic          mode,
    input  logic          _dav,
    output logic          rfd,
    output logic [PW-1:0] p,
    output logic          _dav_out,
    input  logic          rfd_out
);

    state_t        state_q, state_d;
    logic [W:0]    s_q, s_d, s_cap;
    logic [MW-1:0] m_q, m_d;
    logic          rfd_d, dav_out_d;
    logic [PW-1:0] p_d;
    logic          start;
    logic          mul_done;
    logic [PW-1:0] mul_prod;

    // Difference is taken larger-minus-smaller so it never wraps.
    always_comb begin
        s_cap = {1'b0, a} + {1'b0, b};
        if (mode) begin
            s_cap = (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
        end
    end

    shift_add_mul #(
        .SW (W + 1),
        .MW (MW)
    ) u_mul (
        .clock (clock),
        .reset (reset),
        .start (start),
        .s     (s_q),
        .m     (m_q),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        m_d       = m_q;
        rfd_d     = rfd;
        dav_out_d = _dav_out;
        p_d       = p;
        start     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!_dav) begin
                    s_d     = s_cap;
                    m_d     = m;
                    rfd_d   = 1'b0;
                    state_d = S_WAIT;
                end
            end
            // Producer must release _dav before the multiply starts, so a
            // held-low _dav can never cause a second capture.
            S_WAIT: begin
                if (_dav) begin
                    start   = 1'b1;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                if (mul_done) begin
                    p_d       = mul_prod;
                    dav_out_d = 1'b0;
                    state_d   = S_OUT;
                end
            end
            S_OUT: begin
                if (!rfd_out) begin
                    dav_out_d = 1'b1;
                    state_d   = S_ACK;
                end
            end
            S_ACK: begin
                if (rfd_out) begin
                    rfd_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            s_q      <= '0;
            m_q      <= '0;
            rfd      <= 1'b1;
            _dav_out <= 1'b1;
            p        <= '0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            m_q      <= m_d;
            rfd      <= rfd_d;
            _dav_out <= dav_out_d;
            p        <= p_d;
        end
    end

endmodule

// File: tb/tb_abc_scaled_hs.sv
// Self-checking bench for abc_scaled_hs (W=4/MW=3 main instance, W=8/MW=5 latency instance).
// Latency: n/a.
// Backpressure: bench plays both producer and consumer.
module tb_abc_scaled_hs;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] a = '0, b = '0;
    logic [2:0] m = '0;
    logic       mode = 1'b0, dav_n = 1'b1, rfd_out = 1'b1;
    logic       rfd, dav_out_n;
    logic [7:0] p;

    logic [7:0]  a8 = '0, b8 = '0;
    logic [4:0]  m8 = '0;
    logic        mode8 = 1'b0, dav8_n = 1'b1, rfd8_out = 1'b1;
    logic        rfd8, dav8_out_n;
    logic [13:0] p8;

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    logic [7:0] prev_p = '0;
    logic       prev_dov = 1'b1;
    logic       rst_seen = 1'b1;

    always #5 clock = ~clock;

    abc_scaled_hs #(.W(4), .MW(3)) dut (
        .clock(clock), .reset(reset), .a(a), .b(b), .m(m), .mode(mode),
        ._dav(dav_n), .rfd(rfd), .p(p), ._dav_out(dav_out_n), .rfd_out(rfd_out)
    );

    abc_scaled_hs #(.W(8), .MW(5)) dut8 (
        .clock(clock), .reset(reset), .a(a8), .b(b8), .m(m8), .mode(mode8),
        ._dav(dav8_n), .rfd(rfd8), .p(p8), ._dav_out(dav8_out_n), .rfd_out(rfd8_out)
    );

    function automatic int ref_p(input int ia, input int ib, input int im, input int imode);
        int d;
        if (imode != 0) d = (ia > ib) ? ia - ib : ib - ia;
        else            d = ia + ib;
        return im * d;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Model: a capture is any edge where the unit is ready and data is offered.
    always @(posedge clock) begin
        rst_seen = reset;
        if (reset) exp_q.delete();
        else if (rfd === 1'b1 && dav_n === 1'b0) exp_q.push_back(ref_p(a, b, m, mode));
    end

    // Each delivery must match the oldest outstanding model result; p may
    // only move on a delivery or a reset edge.
    always @(negedge clock) begin
        if (prev_dov === 1'b1 && dav_out_n === 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got %0d expected none at %0t", p, $time);
            end else begin
                chk("result", {24'd0, p}, exp_q.pop_front());
            end
        end else if (!rst_seen) begin
            chk("p_stable", {24'd0, p}, {24'd0, prev_p});
        end
        prev_p   = p;
        prev_dov = dav_out_n;
    end

    task automatic send(input logic [3:0] ta, input logic [3:0] tb2, input logic [2:0] tm,
                        input logic tmode, input int dwait, output int cap_t);
        int n;
        @(negedge clock);
        a = ta; b = tb2; m = tm; mode = tmode; dav_n = 1'b0;
        n = 0;
        do begin @(posedge clock); n++; end while (rfd !== 1'b1 && n < 100);
        if (n >= 100) flag("capture_timeout");
        cap_t = int'($time);
        @(negedge clock);
        chk("rfd_low_after_capture", rfd, 0);
        repeat (dwait) begin
            @(negedge clock);
            chk("wait_holds_rfd", rfd, 0);
            chk("wait_no_result", dav_out_n, 1);
        end
        dav_n = 1'b1;
    endtask

    task automatic recv(input int hold, input bit pre0, output int fall_t, output int rise_t);
        int n;
        n = 0;
        while (dav_out_n !== 1'b0 && n < 100) begin @(negedge clock); n++; end
        if (n >= 100) flag("result_timeout");
        fall_t = int'($time) - 5;
        if (!pre0) begin
            repeat (hold) begin
                @(negedge clock);
                chk("slow_dav_out_low", dav_out_n, 0);
                chk("slow_rfd_low", rfd, 0);
            end
            rfd_out = 1'b0;
        end
        @(negedge clock);
        chk("dav_out_release", dav_out_n, 1);
        rfd_out = 1'b1;
        n = 0;
        do begin @(negedge clock); n++; end while (rfd !== 1'b1 && n < 100);
        if (n >= 100) flag("rfd_timeout");
        rise_t = int'($time) - 5;
    endtask

    task automatic txn(input logic [3:0] ta, input logic [3:0] tb2, input logic [2:0] tm,
                       input logic tmode, input int dwait, input int hold, input bit pre0,
                       output int lat, output int turn);
        int c, f, r;
        if (pre0) rfd_out = 1'b0;
        send(ta, tb2, tm, tmode, dwait, c);
        recv(hold, pre0, f, r);
        // Clocks counted inclusive of the capture edge.
        lat  = (f - c) / 10 + 1;
        turn = (r - c) / 10 + 1;
    endtask

    initial begin
        int lat, turn, c, n, t0, t1, t2;
        logic [4:0] iv;
        logic [3:0] ia, ib;

        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, turn, c, n, t0, t1, t2;
        logic [4:0]  iv;
        logic [3:0]  ia, ib;
        logic [7:0]  la [2]  = '{8'd200, 8'd10};
        logic [7:0]  lb [2]  = '{8'd55, 8'd250};
        logic [4:0]  lm [2]  = '{5'd31, 5'd3};
        logic        lmd [2] = '{1'b0, 1'b1};
        int          lexp [2] = '{7905, 720};

        repeat (2) @(negedge clock);
        chk("reset_rfd", rfd, 1);
        chk("reset_dav_out", dav_out_n, 1);
        chk("reset_p", p, 0);
        reset = 1'b0;

        // Backward-compatible add-and-double sequence, also used for latency.
        for (int i = 0; i < 32; i++) begin
            iv = 5'(i);
            ia = 4'(iv[4:1] + 4'd3);
            ib = 4'(iv[3:0] + 4'd1);
            txn(ia, ib, 3'd2, 1'b0, 0, 0, 1'b0, lat, turn);
            chk("compat_p", p, 2 * (ia + ib));
            if (i == 0) begin
                chk("latency_mw3", lat, 5);
                chk("turnaround_mw3", turn, 7);
            end
        end

        txn(4'd3, 4'd12, 3'd5, 1'b1, 1, 0, 1'b0, lat, turn);
        chk("diff_3_12_m5", p, 45);
        txn(4'd9, 4'd9, 3'd5, 1'b1, 0, 0, 1'b0, lat, turn);
        chk("diff_equal", p, 0);
        txn(4'd15, 4'd15, 3'd7, 1'b0, 0, 0, 1'b0, lat, turn);
        chk("max_210", p, 210);
        txn(4'd15, 4'd15, 3'd0, 1'b0, 0, 0, 1'b0, lat, turn);
        chk("m_zero", p, 0);
        txn(4'd6, 4'd4, 3'd3, 1'b0, 2, 20, 1'b0, lat, turn);
        chk("slow_consumer", p, 30);
        txn(4'd1, 4'd2, 3'd1, 1'b0, 0, 0, 1'b1, lat, turn);
        chk("fast_consumer", p, 3);

        // _dav offered again during OUT/ACK must wait for IDLE.
        send(4'd7, 4'd2, 3'd3, 1'b1, 0, c);
        n = 0;
        while (dav_out_n !== 1'b0 && n < 100) begin @(negedge clock); n++; end
        if (n >= 100) flag("early_dav_timeout");
        a = 4'd4; b = 4'd11; m = 3'd6; mode = 1'b0; dav_n = 1'b0;
        chk("early_dav_first_p", p, 15);
        rfd_out = 1'b0;
        @(negedge clock);
        chk("early_dav_rfd_out", rfd, 0);
        rfd_out = 1'b1;
        @(negedge clock);
        chk("early_dav_rfd_ack", rfd, 1);
        @(negedge clock);
        chk("early_dav_captured", rfd, 0);
        dav_n = 1'b1;
        recv(0, 1'b0, t0, t1);
        chk("early_dav_second_p", p, 90);

        // Reset while multiplying: pending result is dropped.
        send(4'd5, 4'd6, 3'd3, 1'b0, 0, c);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midreset_rfd", rfd, 1);
        chk("midreset_dav_out", dav_out_n, 1);
        chk("midreset_p", p, 0);
        repeat (10) begin
            @(negedge clock);
            chk("midreset_no_stale", dav_out_n, 1);
        end
        txn(4'd5, 4'd6, 3'd3, 1'b0, 0, 0, 1'b0, lat, turn);
        chk("after_reset_p", p, 33);

        // Random traffic against the model.
        for (int k = 0; k < 40; k++) begin
            txn(4'($urandom), 4'($urandom), 3'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                1'($urandom_range(0, 1)), lat, turn);
        end

        // Wider instance latency and value.
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            a8 = la[k]; b8 = lb[k]; m8 = lm[k]; mode8 = lmd[k]; dav8_n = 1'b0;
            n = 0;
            do begin @(posedge clock); n++; end while (rfd8 !== 1'b1 && n < 100);
            if (n >= 100) flag("w8_capture_timeout");
            t0 = int'($time);
            @(negedge clock);
            dav8_n = 1'b1;
            n = 0;
            while (dav8_out_n !== 1'b0 && n < 100) begin @(negedge clock); n++; end
            if (n >= 100) flag("w8_result_timeout");
            t1 = int'($time) - 5;
            chk("w8_latency", (t1 - t0) / 10 + 1, 7);
            chk("w8_p", p8, lexp[k]);
            rfd8_out = 1'b0;
            @(negedge clock);
            chk("w8_dav_out_release", dav8_out_n, 1);
            rfd8_out = 1'b1;
            n = 0;
            do begin @(negedge clock); n++; end while (rfd8 !== 1'b1 && n < 100);
            if (n >= 100) flag("w8_rfd_timeout");
            t2 = int'($time) - 5;
            chk("w8_turnaround", (t2 - t0) / 10 + 1, 9);
        end

        repeat (3) @(negedge clock);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
